// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch FSM with branch/jump redirect.
// Ports:
//   clk, reset_n                     clock and asynchronous active-low reset
//   branch, branch_target            taken-branch flag and destination
//   jump, jump_target                jump flag and destination (wins over branch)
//   imem_req_valid/addr/ready        instruction-memory request handshake
//   imem_resp_valid/data             instruction-memory response
//   inst_valid/data/pc, inst_ready   instruction handed to decode
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_t;
  state_t      state, state_n;
  logic [31:0] pc, pc_n, target_raw, target;
  logic        discard, discard_n, load, redirect;
  assign redirect       = branch | jump;
  assign target_raw     = jump ? jump_target : branch_target;
  assign target         = {target_raw[31:2], 2'b00};
  // Request is held off while in reset so it rises only once reset is released.
  assign imem_req_valid = reset_n && state == S_FETCH;
  assign imem_req_addr  = pc;
  assign inst_valid     = state == S_HOLD;
  always_comb begin
    state_n   = state;
    pc_n      = redirect ? target : pc;
    discard_n = discard;
    load      = 1'b0;
    case (state)
      S_FETCH: begin
        if (imem_req_valid && imem_req_ready) begin
          state_n   = S_WAIT;
          discard_n = redirect;
        end
      end
      S_WAIT: begin
        // A redirect coinciding with the response drops it directly, so the
        // discard flag never has to be set for it.
        if (imem_resp_valid) begin
          load      = !(redirect || discard);
          state_n   = load ? S_HOLD : S_FETCH;
          discard_n = 1'b0;
          if (load) pc_n = pc + 32'd4;
        end else if (redirect) begin
          discard_n = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect || inst_ready) state_n = S_FETCH;
      end
      default: state_n = S_FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      discard   <= 1'b0;
      inst_data <= 32'h0;
      inst_pc   <= 32'h0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      discard <= discard_n;
      if (load) begin
        inst_data <= imem_resp_data;
        inst_pc   <= pc;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
module tb_fetch_unit;
  logic        clk, reset_n, branch, jump, imem_req_valid, imem_req_ready;
  logic        imem_resp_valid, inst_valid, inst_ready;
  logic [31:0] branch_target, jump_target, imem_req_addr, imem_resp_data;
  logic [31:0] inst_data, inst_pc;
  int checks = 0;
  int failures = 0;

  fetch_unit dut (
    .clk(clk), .reset_n(reset_n),
    .branch(branch), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    branch = 0; jump = 0; branch_target = 0; jump_target = 0;
    imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0; inst_ready = 0;
    reset_n = 0;
    step();
    step();
    reset_n = 1;
    #1;
  endtask

  task automatic test_reset();
    branch = 0; jump = 0; branch_target = 0; jump_target = 0;
    imem_req_ready = 1; imem_resp_valid = 0; imem_resp_data = 0; inst_ready = 0;
    reset_n = 0;
    step();
    step();
    checks++;
    if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
    checks++;
    if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_inst_valid got=%b exp=0", inst_valid); end
    checks++;
    if (inst_data !== 32'h0 || inst_pc !== 32'h0) begin failures++; $display("FAIL reset_inst got data=%h pc=%h exp=0/0", inst_data, inst_pc); end
    imem_req_ready = 0;
    reset_n = 1;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin failures++; $display("FAIL reset_first_req got v=%b a=%h exp=1/0", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * i)) begin failures++; $display("FAIL seq_req%0d got v=%b a=%h exp=1/%h", i, imem_req_valid, imem_req_addr, 32'(4 * i)); end
      imem_req_ready = 1;
      step();
      imem_req_ready = 0;
      checks++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("FAIL seq_wait%0d got rv=%b iv=%b exp=0/0", i, imem_req_valid, inst_valid); end
      imem_resp_valid = 1;
      imem_resp_data = 32'h1000_0000 + 32'(i);
      step();
      imem_resp_valid = 0;
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * i) || inst_data !== 32'h1000_0000 + 32'(i)) begin failures++; $display("FAIL seq_inst%0d got v=%b pc=%h d=%h exp=1/%h/%h", i, inst_valid, inst_pc, inst_data, 32'(4 * i), 32'h1000_0000 + 32'(i)); end
      inst_ready = 1;
      step();
      inst_ready = 0;
      checks++;
      if (inst_valid !== 1'b0) begin failures++; $display("FAIL seq_consume%0d got=%b exp=0", i, inst_valid); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    imem_req_ready = 1;
    step();
    imem_req_ready = 0;
    imem_resp_valid = 1;
    imem_resp_data = 32'hAAAA_0000;
    step();
    imem_resp_valid = 0;
    inst_ready = 1;
    step();
    inst_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin failures++; $display("FAIL stall_addr%0d got v=%b a=%h exp=1/4", i, imem_req_valid, imem_req_addr); end
    end
    imem_req_ready = 1;
    step();
    imem_req_ready = 0;
    checks++;
    if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_accept got=%b exp=0", imem_req_valid); end
    imem_resp_valid = 1;
    imem_resp_data = 32'hAAAA_0004;
    step();
    imem_resp_valid = 0;
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst_data !== 32'hAAAA_0004) begin failures++; $display("FAIL stall_inst got v=%b pc=%h d=%h exp=1/4/aaaa0004", inst_valid, inst_pc, inst_data); end
    inst_ready = 1;
    step();
    inst_ready = 0;
  endtask

  task automatic test_branch_wait();
    imem_req_ready = 1;
    step();
    imem_req_ready = 0;
    branch = 1;
    branch_target = 32'h100;
    step();
    branch = 0;
    checks++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin failures++; $display("FAIL br_wait got iv=%b rv=%b exp=0/0", inst_valid, imem_req_valid); end
    imem_resp_valid = 1;
    imem_resp_data = 32'hDEAD_0008;
    step();
    imem_resp_valid = 0;
    checks++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin failures++; $display("FAIL br_drop got iv=%b rv=%b a=%h exp=0/1/100", inst_valid, imem_req_valid, imem_req_addr); end
    imem_req_ready = 1;
    step();
    imem_req_ready = 0;
    imem_resp_valid = 1;
    imem_resp_data = 32'hBBBB_0100;
    step();
    imem_resp_valid = 0;
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst_data !== 32'hBBBB_0100) begin failures++; $display("FAIL br_inst got v=%b pc=%h d=%h exp=1/100/bbbb0100", inst_valid, inst_pc, inst_data); end
    inst_ready = 1;
    step();
    inst_ready = 0;
  endtask

  task automatic test_redirect_cases();
    jump = 1; jump_target = 32'h203;
    branch = 1; branch_target = 32'h40;
    step();
    jump = 0; branch = 0;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin failures++; $display("FAIL jump_prio got v=%b a=%h exp=1/200", imem_req_valid, imem_req_addr); end
    imem_req_ready = 1;
    branch = 1; branch_target = 32'h300;
    step();
    imem_req_ready = 0; branch = 0;
    imem_resp_valid = 1;
    imem_resp_data = 32'hDEAD_0200;
    step();
    imem_resp_valid = 0;
    checks++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin failures++; $display("FAIL redir_hs got iv=%b rv=%b a=%h exp=0/1/300", inst_valid, imem_req_valid, imem_req_addr); end
    imem_req_ready = 1;
    step();
    imem_req_ready = 0;
    branch = 1; branch_target = 32'h50;
    imem_resp_valid = 1;
    imem_resp_data = 32'hDEAD_0300;
    step();
    branch = 0; imem_resp_valid = 0;
    checks++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h50) begin failures++; $display("FAIL redir_resp got iv=%b rv=%b a=%h exp=0/1/50", inst_valid, imem_req_valid, imem_req_addr); end
    imem_req_ready = 1;
    step();
    imem_req_ready = 0;
    imem_resp_valid = 1;
    imem_resp_data = 32'hCCCC_0050;
    step();
    imem_resp_valid = 0;
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h50 || inst_data !== 32'hCCCC_0050) begin failures++; $display("FAIL redir_next got v=%b pc=%h d=%h exp=1/50/cccc0050", inst_valid, inst_pc, inst_data); end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 4; i++) begin
      imem_resp_valid = (i == 1);
      imem_resp_data = 32'hBAD0_0000;
      step();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h50 || inst_data !== 32'hCCCC_0050 || imem_req_valid !== 1'b0) begin failures++; $display("FAIL hold%0d got v=%b pc=%h d=%h rv=%b exp=1/50/cccc0050/0", i, inst_valid, inst_pc, inst_data, imem_req_valid); end
    end
    imem_resp_valid = 0;
    branch = 1; branch_target = 32'h80; inst_ready = 1;
    step();
    branch = 0; inst_ready = 0;
    checks++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80) begin failures++; $display("FAIL hold_redir got iv=%b rv=%b a=%h exp=0/1/80", inst_valid, imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_wrap();
    jump = 1; jump_target = 32'hFFFF_FFFF;
    step();
    jump = 0;
    checks++;
    if (imem_req_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_align got=%h exp=fffffffc", imem_req_addr); end
    imem_req_ready = 1;
    step();
    imem_req_ready = 0;
    imem_resp_valid = 1;
    imem_resp_data = 32'hEEEE_FFFC;
    step();
    imem_resp_valid = 0;
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst_data !== 32'hEEEE_FFFC) begin failures++; $display("FAIL wrap_inst got v=%b pc=%h d=%h exp=1/fffffffc/eeeefffc", inst_valid, inst_pc, inst_data); end
    inst_ready = 1;
    step();
    inst_ready = 0;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin failures++; $display("FAIL wrap_next got v=%b a=%h exp=1/0", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_reset_mid();
    jump = 1; jump_target = 32'h600;
    step();
    jump = 0;
    imem_req_ready = 1;
    step();
    imem_req_ready = 0;
    #2;
    reset_n = 0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst_pc !== 32'h0) begin failures++; $display("FAIL rst_mid got rv=%b iv=%b pc=%h exp=0/0/0", imem_req_valid, inst_valid, inst_pc); end
    step();
    reset_n = 1;
    imem_resp_valid = 1;
    imem_resp_data = 32'hDEAD_0600;
    step();
    imem_resp_valid = 0;
    checks++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin failures++; $display("FAIL rst_late got iv=%b rv=%b a=%h exp=0/1/0", inst_valid, imem_req_valid, imem_req_addr); end
    imem_req_ready = 1;
    step();
    imem_req_ready = 0;
    imem_resp_valid = 1;
    imem_resp_data = 32'h1234_5678;
    step();
    imem_resp_valid = 0;
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'h1234_5678) begin failures++; $display("FAIL rst_refetch got v=%b pc=%h d=%h exp=1/0/12345678", inst_valid, inst_pc, inst_data); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_wait();
    test_redirect_cases();
    test_hold();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL give the PC value loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 branch  input  1  SHALL be the taken-branch flag from the branch comparator.
REQ-005 branch_target  input  32  SHALL be the branch destination address.
REQ-006 jump  input  1  SHALL be the unconditional jump flag (JAL/JALR).
REQ-007 jump_target  input  32  SHALL be the jump destination address.
REQ-008 imem_req_valid  output  1  SHALL flag an instruction-memory read request.
REQ-009 imem_req_addr  output  32  SHALL carry the request address, equal to the PC.
REQ-010 imem_req_ready  input  1  SHALL accept the request when high together with imem_req_valid.
REQ-011 imem_resp_valid  input  1  SHALL flag returned instruction data.
REQ-012 imem_resp_data  input  32  SHALL carry the returned instruction word.
REQ-013 inst_valid  output  1  SHALL flag a valid instruction to decode.
REQ-014 inst_data  output  32  SHALL carry the instruction word.
REQ-015 inst_pc  output  32  SHALL carry the address of inst_data.
REQ-016 inst_ready  input  1  SHALL indicate decode consumes the instruction this cycle.

Function
REQ-017 The FSM SHALL have the states FETCH (imem_req_valid=1), WAIT (one request outstanding) and HOLD (inst_valid=1), plus a discard flag.
REQ-018 At most one imem request SHALL be outstanding.
REQ-019 FETCH: on imem_req_valid & imem_req_ready -> WAIT; otherwise stay, with imem_req_addr stable unless a redirect occurs.
REQ-020 WAIT: on imem_resp_valid with discard=0 -> load inst_data=imem_resp_data, inst_pc=PC, PC<=PC+4 (mod 2^32 wrap), -> HOLD.
REQ-021 WAIT: on imem_resp_valid with discard=1 -> drop the data, clear discard, -> FETCH.
REQ-022 HOLD: on inst_ready -> FETCH next cycle; inst_valid, inst_data and inst_pc SHALL otherwise stay stable.
REQ-023 Redirect = branch | jump; the target SHALL be jump_target when jump=1, else branch_target (jump wins when both are high).
REQ-024 The redirect target SHALL be loaded into PC with bits [1:0] forced to 0, at the edge closing the redirect cycle.
REQ-025 Redirect in FETCH without handshake: stay FETCH; the new address SHALL appear on the next cycle.
REQ-026 Redirect in FETCH with a same-cycle handshake: -> WAIT with discard=1.
REQ-027 Redirect in WAIT: discard<=1; if imem_resp_valid is high in the same cycle, the response SHALL be dropped and the FSM SHALL go to FETCH with discard=0.
REQ-028 Redirect in HOLD: inst_valid SHALL drop next cycle, the instruction is lost even if inst_ready=1, -> FETCH.
REQ-029 A repeated redirect while discard=1 SHALL only update PC; discard stays 1.
REQ-030 imem_resp_valid outside WAIT SHALL be ignored.
REQ-031 The minimum fetch-to-issue latency SHALL be 2 cycles: request accept -> response -> inst_valid on the following cycle.

Reset
REQ-032 While reset_n=0: PC=RESET_PC, state FETCH, discard=0, imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0.
REQ-033 imem_req_valid SHALL rise in the first cycle after reset_n deasserts, with imem_req_addr=RESET_PC.
REQ-034 Reset asserted mid-WAIT or mid-HOLD SHALL abandon the operation immediately; a late response SHALL be ignored (state FETCH, not WAIT).

Verification
REQ-035 Sequential fetch, memory always ready, 1-cycle response -> inst_pc sequence 0x0, 0x4, 0x8 with matching data.
REQ-036 imem_req_ready held low 3 cycles -> imem_req_addr stable at 0x4 throughout; accepted on cycle 4.
REQ-037 branch=1, branch_target=0x100 in WAIT for addr 0x8 -> the 0x8 response is dropped; next inst_pc=0x100, no inst_valid for 0x8.
REQ-038 jump=1, jump_target=0x203, and branch=1, branch_target=0x40, same cycle -> next request addr=0x200.
REQ-039 inst_ready low 4 cycles in HOLD -> inst_valid, inst_data and inst_pc constant; then redirect -> inst_valid=0 next cycle.
REQ-040 reset_n pulsed low during WAIT, response arriving after release -> ignored; first request addr=RESET_PC.
